// File: rtl/reg_file_pkg.sv
// Shared register-file constants and the register-index type used by
// the decode and writeback stages.
package reg_file_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Two-read, one-write register file: writes commit on the rising edge,
// both read ports are registered on the falling edge of the same clock.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int DEPTH_P  = DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write,
    input  logic [ADDR_W_P-1:0] PR1,
    input  logic [ADDR_W_P-1:0] PR2,
    input  logic [ADDR_W_P-1:0] WR,
    input  logic [DATA_W_P-1:0] WD,
    output logic [DATA_W_P-1:0] RD1,
    output logic [DATA_W_P-1:0] RD2
);

    logic [DATA_W_P-1:0] rf_mem [DEPTH_P];
    logic [DATA_W_P-1:0] rd1_d, rd2_d;
    logic [DATA_W_P-1:0] rd1_q, rd2_q;

    // NOTE: the array is built from resettable flops rather than a RAM
    // macro, because every entry must take its own index on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_P; i++) begin
                rf_mem[i] <= DATA_W_P'(i);
            end
        end else if (write && (WR != '0)) begin
            // NOTE: non-blocking so the falling-edge read process sees a
            // stable array value, never a race with this update.
            rf_mem[WR] <= WD;
        end
    end

    always_comb begin
        rd1_d = rf_mem[PR1];
        rd2_d = rf_mem[PR2];
    end

    // The half-cycle split lets a read see the write from the preceding
    // rising edge without a bypass path.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign RD1 = rd1_q;
    assign RD2 = rd2_q;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases plus random traffic
// compared against an array model of the register file.
module tb_reg_file;
    import reg_file_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              write;
    logic [ADDR_W-1:0] PR1, PR2, WR;
    logic [DATA_W-1:0] WD;
    logic [DATA_W-1:0] RD1, RD2;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] prev_rd1, prev_rd2;

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .PR1   (PR1),
        .PR2   (PR2),
        .WR    (WR),
        .WD    (WD),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = DATA_W'(i);
        prev_rd1 = '0;
        prev_rd2 = '0;
    endfunction

    // One full cycle: drive, cross the rising edge, confirm the outputs
    // held, cross the falling edge, compare against the model.
    task automatic cycle(input string tag, input logic w, input logic [ADDR_W-1:0] wr,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] p1,
                         input logic [ADDR_W-1:0] p2);
        write = w;
        WR    = wr;
        WD    = wd;
        PR1   = p1;
        PR2   = p2;
        @(posedge clk);
        #1;
        check({tag, "_hold1"}, RD1, prev_rd1);
        check({tag, "_hold2"}, RD2, prev_rd2);
        if (w && wr != '0) model[wr] = wd;
        @(negedge clk);
        #1;
        prev_rd1 = model[p1];
        prev_rd2 = model[p2];
        check({tag, "_rd1"}, RD1, prev_rd1);
        check({tag, "_rd2"}, RD2, prev_rd2);
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0;
        WR    = '0;
        WD    = '0;
        PR1   = '0;
        PR2   = '0;
        model_reset();
        #1;
        check("reset_rd1", RD1, '0);
        check("reset_rd2", RD2, '0);
        #1 reset = 1'b0;

        cycle("init_read", 1'b0, 5'd0, 32'd0, 5'd6, 5'd8);
        cycle("write_r4", 1'b1, 5'd4, 32'd31, 5'd0, 5'd0);
        cycle("read_r4", 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);

        // Asynchronous reset in the middle of a cycle.
        PR1 = 5'd4;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("async_rst_rd1", RD1, '0);
        check("async_rst_rd2", RD2, '0);
        #1 reset = 1'b0;
        cycle("post_rst", 1'b0, 5'd0, 32'd0, 5'd10, 5'd12);
        cycle("r4_reinit", 1'b0, 5'd0, 32'd0, 5'd4, 5'd4);

        cycle("same_cycle", 1'b1, 5'd1, 32'd20, 5'd1, 5'd2);
        cycle("r0_write", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cycle("no_write", 1'b0, 5'd3, 32'd99, 5'd0, 5'd3);
        cycle("same_port", 1'b0, 5'd0, 32'd0, 5'd31, 5'd31);

        // Reset held across a rising edge with write pending, then a
        // falling edge: no write, outputs stay cleared.
        write = 1'b1;
        WR    = 5'd5;
        WD    = 32'd77;
        PR1   = 5'd5;
        PR2   = 5'd1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        model_reset();
        check("rst_hold_rd1", RD1, '0);
        check("rst_hold_rd2", RD2, '0);
        reset = 1'b0;
        cycle("rst_beats_wr", 1'b0, 5'd0, 32'd0, 5'd5, 5'd1);

        for (int n = 0; n < 300; n++) begin
            logic              w;
            logic [ADDR_W-1:0] wr, p1, p2;
            logic [DATA_W-1:0] wd;
            w  = 1'($urandom_range(0, 1));
            wr = ADDR_W'($urandom_range(0, DEPTH - 1));
            wd = $urandom();
            p1 = ($urandom_range(0, 3) == 0) ? wr : ADDR_W'($urandom_range(0, DEPTH - 1));
            p2 = ADDR_W'($urandom_range(0, DEPTH - 1));
            cycle("rand", w, wr, wd, p1, p2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
